// File: rtl/regfile_access_master.sv
// regfile_access_master
// ---------------------
// Initiator-side controller for the 32x32 register file. Accepts one request
// at a time from the multi-cycle control unit (READ, WRITE, CLEAR, NOP) and
// turns it into register file port activity. Read results are returned on a
// separate valid/ready response channel. Every output is registered.
//
// Optional feature: define REGFILE_WRITE_VERIFY_EN to add a read-back check
// after each WRITE (extra VERIFY state and a sticky wr_err output).
//
// Ports:
//   clk, rst_n                     clock (posedge), async active-low reset
//   req_valid/req_ready            request handshake
//   req_op                         00 READ, 01 WRITE, 10 CLEAR, 11 NOP
//   req_rs1/req_rs2/req_rd         read / write addresses
//   req_wdata                      write data
//   rsp_valid/rsp_ready            read response handshake
//   rsp_data1/rsp_data2            data read from rs1 / rs2
//   done                           one-cycle pulse on WRITE/CLEAR/NOP completion
//   wr_err                         sticky write-verify error (feature only)
//   rf_read_reg1/2, rf_write_reg,
//   rf_write_data, rf_write_enable register file controls
//   rf_read_data1/2                combinational read data from register file
module regfile_access_master #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic              done,
`ifdef REGFILE_WRITE_VERIFY_EN
    output logic              wr_err,
`endif
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2
);

    localparam logic [1:0]        OP_READ  = 2'b00;
    localparam logic [1:0]        OP_WRITE = 2'b01;
    localparam logic [1:0]        OP_CLEAR = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_RSP    = 3'd2,
        ST_WRITE  = 3'd3,
        ST_CLEAR  = 3'd4
`ifdef REGFILE_WRITE_VERIFY_EN
        ,
        ST_VERIFY = 3'd5
`endif
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                req_ready_s;
    logic                rsp_valid_s;
    logic [DATA_W-1:0]   rsp_data1_s;
    logic [DATA_W-1:0]   rsp_data2_s;
    logic                done_s;
    logic [ADDR_W-1:0]   rf_read_reg1_s;
    logic [ADDR_W-1:0]   rf_read_reg2_s;
    logic [ADDR_W-1:0]   rf_write_reg_s;
    logic [DATA_W-1:0]   rf_write_data_s;
    logic                rf_write_enable_s;
`ifdef REGFILE_WRITE_VERIFY_EN
    logic                wr_err_s;
`endif

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so that the registered outputs line up with that state.
    always_comb begin
        state_s           = state_r;
        rsp_valid_s       = rsp_valid;
        rsp_data1_s       = rsp_data1;
        rsp_data2_s       = rsp_data2;
        done_s            = 1'b0;
        rf_read_reg1_s    = rf_read_reg1;
        rf_read_reg2_s    = rf_read_reg2;
        rf_write_reg_s    = rf_write_reg;
        rf_write_data_s   = rf_write_data;
        rf_write_enable_s = 1'b0;
`ifdef REGFILE_WRITE_VERIFY_EN
        wr_err_s          = wr_err;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    case (req_op)
                        OP_READ: begin
                            state_s        = ST_READ;
                            rf_read_reg1_s = req_rs1;
                            rf_read_reg2_s = req_rs2;
                        end
                        OP_WRITE: begin
                            state_s           = ST_WRITE;
                            rf_write_enable_s = 1'b1;
                            rf_write_reg_s    = req_rd;
                            rf_write_data_s   = req_wdata;
`ifdef REGFILE_WRITE_VERIFY_EN
                            done_s            = 1'b0;
`else
                            done_s            = 1'b1;
`endif
                        end
                        OP_CLEAR: begin
                            state_s           = ST_CLEAR;
                            rf_write_enable_s = 1'b1;
                            rf_write_reg_s    = {ADDR_W{1'b0}};
                            rf_write_data_s   = {DATA_W{1'b0}};
                            done_s            = (LAST_REG == {ADDR_W{1'b0}});
                        end
                        default: begin
                            // Reserved op: complete immediately, no RF activity.
                            state_s = ST_IDLE;
                            done_s  = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                // rf_read_reg1/2 have been stable all cycle; capture the data.
                state_s     = ST_RSP;
                rsp_valid_s = 1'b1;
                rsp_data1_s = rf_read_data1;
                rsp_data2_s = rf_read_data2;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b0;
                end else begin
                    state_s     = ST_RSP;
                end
            end
            ST_WRITE: begin
`ifdef REGFILE_WRITE_VERIFY_EN
                // Point read port 1 at the just-written register for read-back.
                state_s        = ST_VERIFY;
                rf_read_reg1_s = rf_write_reg;
                done_s         = 1'b1;
`else
                state_s        = ST_IDLE;
`endif
            end
`ifdef REGFILE_WRITE_VERIFY_EN
            ST_VERIFY: begin
                state_s = ST_IDLE;
                if (rf_read_data1 != rf_write_data) begin
                    wr_err_s = 1'b1;
                end else begin
                    wr_err_s = wr_err;
                end
            end
`endif
            ST_CLEAR: begin
                if (rf_write_reg == LAST_REG) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s           = ST_CLEAR;
                    rf_write_enable_s = 1'b1;
                    rf_write_reg_s    = rf_write_reg + ADDR_ONE;
                    done_s            = ((rf_write_reg + ADDR_ONE) == LAST_REG);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        req_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            req_ready       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_data1       <= {DATA_W{1'b0}};
            rsp_data2       <= {DATA_W{1'b0}};
            done            <= 1'b0;
            rf_read_reg1    <= {ADDR_W{1'b0}};
            rf_read_reg2    <= {ADDR_W{1'b0}};
            rf_write_reg    <= {ADDR_W{1'b0}};
            rf_write_data   <= {DATA_W{1'b0}};
            rf_write_enable <= 1'b0;
`ifdef REGFILE_WRITE_VERIFY_EN
            wr_err          <= 1'b0;
`endif
        end else begin
            state_r         <= state_s;
            req_ready       <= req_ready_s;
            rsp_valid       <= rsp_valid_s;
            rsp_data1       <= rsp_data1_s;
            rsp_data2       <= rsp_data2_s;
            done            <= done_s;
            rf_read_reg1    <= rf_read_reg1_s;
            rf_read_reg2    <= rf_read_reg2_s;
            rf_write_reg    <= rf_write_reg_s;
            rf_write_data   <= rf_write_data_s;
            rf_write_enable <= rf_write_enable_s;
`ifdef REGFILE_WRITE_VERIFY_EN
            wr_err          <= wr_err_s;
`endif
        end
    end

endmodule
